// File: rtl/pw_trigger_pkg.sv
// Shared types and defaults for the cw_trig pulse-train sequencer.
// The state enum and default field widths live here so the top level and
// any future siblings agree on the encoding and sizing.
package pw_trigger_pkg;

  // Default field widths for the sequencer parameters.
  localparam int DEFAULT_DELAY_WIDTH = 20;
  localparam int DEFAULT_WIDTH_WIDTH = 8;
  localparam int DEFAULT_COUNT_WIDTH = 4;

  // Sequencer states. IDLE waits for an arm request, ARMED waits for a
  // match, DELAY counts out the post-match delay, PULSE drives the trigger
  // high and GAP holds it low between pulses.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    DELAY = 3'd2,
    PULSE = 3'd3,
    GAP   = 3'd4
  } trig_state_e;

  // Larger of two widths, used to size the shared down-counter so it can
  // hold either a full delay value or a full width/gap value.
  function automatic int maxWidth(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pw_load_counter.sv
// Loadable down-counter with a zero flag.
// One instance is time-shared by the sequencer for the post-match delay,
// the pulse width and the inter-pulse gap, since only one of those phases
// is ever active at a time. The count saturates at zero rather than
// wrapping, so a stray decrement can never produce a huge delay.
module pw_load_counter #(
  parameter int pCNT_WIDTH = 20
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_i,
  input  logic [pCNT_WIDTH-1:0] load_val_i,
  input  logic                  dec_i,
  output logic                  zero_o
);

  logic [pCNT_WIDTH-1:0] cnt_q;
  logic [pCNT_WIDTH-1:0] cnt_d;

  // Load takes priority over decrement; decrement stops at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - pCNT_WIDTH'(1);
    end
  end

  // Count register, cleared by the asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pw_trigger_seq.sv
// Trigger sequencer for the cw_trig pin, in the trigger_clk domain.
// After an arm request the block waits for a match, counts out a delay,
// then emits a train of N+1 pulses, each W+1 cycles high separated by
// G+1 cycles low. The configuration is captured at arm time so the
// register interface may change freely while a train is running. Every
// output is registered from the next-state value so the pin sees clean
// edges aligned to the state changes.
module pw_trigger_seq
  import pw_trigger_pkg::*;
#(
  parameter int pDELAY_WIDTH = DEFAULT_DELAY_WIDTH,
  parameter int pWIDTH_WIDTH = DEFAULT_WIDTH_WIDTH,
  parameter int pCOUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
  input  logic                    trigger_clk,
  input  logic                    reset_n,
  input  logic                    I_arm,
  input  logic                    I_abort,
  input  logic                    I_rearm,
  input  logic                    I_match,
  input  logic [pDELAY_WIDTH-1:0] I_delay,
  input  logic [pWIDTH_WIDTH-1:0] I_width,
  input  logic [pWIDTH_WIDTH-1:0] I_gap,
  input  logic [pCOUNT_WIDTH-1:0] I_num_pulses,
  output logic                    O_trigger,
  output logic                    O_armed,
  output logic                    O_busy,
  output logic                    O_done,
  output logic                    O_missed
);

  // The shared counter must hold the longest of delay, width and gap.
  localparam int CNT_WIDTH = maxWidth(pDELAY_WIDTH, pWIDTH_WIDTH);

  trig_state_e state_q, state_d;

  // Configuration captured at arm time.
  logic [pDELAY_WIDTH-1:0] delay_q, delay_d;
  logic [pWIDTH_WIDTH-1:0] width_q, width_d;
  logic [pWIDTH_WIDTH-1:0] gap_q, gap_d;
  logic [pCOUNT_WIDTH-1:0] num_q, num_d;
  logic                    rearm_q, rearm_d;

  // Index of the pulse currently being emitted (0-based).
  logic [pCOUNT_WIDTH-1:0] pulseCnt_q, pulseCnt_d;

  // Registered outputs.
  logic trigger_q, trigger_d;
  logic armed_q, armed_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic missed_q, missed_d;

  // Shared counter control.
  logic                 cntLoad;
  logic [CNT_WIDTH-1:0] cntLoadVal;
  logic                 cntDec;
  logic                 cntZero;

  // Pre-extended load values. The delay phase is loaded with D-1 because
  // the ARMED cycle that sees the match already accounts for one cycle of
  // the overall t+1+D latency; D=0 skips the delay phase entirely, so the
  // subtraction is only ever used with D>=1 and the full-scale D is exact.
  logic [pDELAY_WIDTH-1:0] delayMinusOne;
  logic [CNT_WIDTH-1:0]    delayLoad;
  logic [CNT_WIDTH-1:0]    widthLoad;
  logic [CNT_WIDTH-1:0]    gapLoad;

  assign delayMinusOne = delay_q - pDELAY_WIDTH'(1);
  assign delayLoad     = CNT_WIDTH'(delayMinusOne);
  assign widthLoad     = CNT_WIDTH'(width_q);
  assign gapLoad       = CNT_WIDTH'(gap_q);

  pw_load_counter #(
    .pCNT_WIDTH(CNT_WIDTH)
  ) u_phase_counter (
    .clk_i      (trigger_clk),
    .rst_ni     (reset_n),
    .load_i     (cntLoad),
    .load_val_i (cntLoadVal),
    .dec_i      (cntDec),
    .zero_o     (cntZero)
  );

  // Next-state, counter control and output decode; abort overrides all.
  always_comb begin
    state_d    = state_q;
    delay_d    = delay_q;
    width_d    = width_q;
    gap_d      = gap_q;
    num_d      = num_q;
    rearm_d    = rearm_q;
    pulseCnt_d = pulseCnt_q;
    cntLoad    = 1'b0;
    cntLoadVal = '0;
    cntDec     = 1'b0;
    done_d     = 1'b0;
    missed_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (I_arm) begin
          delay_d = I_delay;
          width_d = I_width;
          gap_d   = I_gap;
          num_d   = I_num_pulses;
          rearm_d = I_rearm;
          state_d = ARMED;
        end
      end

      ARMED: begin
        if (I_match) begin
          pulseCnt_d = '0;
          cntLoad    = 1'b1;
          if (delay_q == '0) begin
            state_d    = PULSE;
            cntLoadVal = widthLoad;
          end else begin
            state_d    = DELAY;
            cntLoadVal = delayLoad;
          end
        end
      end

      DELAY: begin
        missed_d = I_match;
        if (cntZero) begin
          state_d    = PULSE;
          cntLoad    = 1'b1;
          cntLoadVal = widthLoad;
        end else begin
          cntDec = 1'b1;
        end
      end

      PULSE: begin
        missed_d = I_match;
        if (cntZero) begin
          if (pulseCnt_q == num_q) begin
            done_d  = 1'b1;
            state_d = rearm_q ? ARMED : IDLE;
          end else begin
            state_d    = GAP;
            cntLoad    = 1'b1;
            cntLoadVal = gapLoad;
            pulseCnt_d = pulseCnt_q + pCOUNT_WIDTH'(1);
          end
        end else begin
          cntDec = 1'b1;
        end
      end

      GAP: begin
        missed_d = I_match;
        if (cntZero) begin
          state_d    = PULSE;
          cntLoad    = 1'b1;
          cntLoadVal = widthLoad;
        end else begin
          cntDec = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort wins over arm and match: drop back to IDLE with counters
    // cleared, keep the previous configuration, and report nothing.
    if (I_abort) begin
      state_d    = IDLE;
      delay_d    = delay_q;
      width_d    = width_q;
      gap_d      = gap_q;
      num_d      = num_q;
      rearm_d    = rearm_q;
      pulseCnt_d = '0;
      cntLoad    = 1'b1;
      cntLoadVal = '0;
      cntDec     = 1'b0;
      done_d     = 1'b0;
      missed_d   = 1'b0;
    end

    trigger_d = (state_d == PULSE);
    armed_d   = (state_d == ARMED);
    busy_d    = (state_d == DELAY) || (state_d == PULSE) || (state_d == GAP);
  end

  // State, configuration and output registers with asynchronous clear, so
  // a reset mid-train drops the trigger pin immediately.
  always_ff @(posedge trigger_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      delay_q    <= '0;
      width_q    <= '0;
      gap_q      <= '0;
      num_q      <= '0;
      rearm_q    <= 1'b0;
      pulseCnt_q <= '0;
      trigger_q  <= 1'b0;
      armed_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      missed_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      delay_q    <= delay_d;
      width_q    <= width_d;
      gap_q      <= gap_d;
      num_q      <= num_d;
      rearm_q    <= rearm_d;
      pulseCnt_q <= pulseCnt_d;
      trigger_q  <= trigger_d;
      armed_q    <= armed_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      missed_q   <= missed_d;
    end
  end

  assign O_trigger = trigger_q;
  assign O_armed   = armed_q;
  assign O_busy    = busy_q;
  assign O_done    = done_q;
  assign O_missed  = missed_q;

endmodule

// File: tb/tb_pw_trigger_seq.sv
// Testbench for pw_trigger_seq: directed scenarios followed by randomized
// arm/match/abort traffic, checked every cycle against a timeline model
// built from the pulse-train arithmetic.
module tb_pw_trigger_seq;

  // Narrower delay field keeps the full-scale delay case short.
  localparam int DW = 12;
  localparam int WW = 8;
  localparam int NW = 4;

  logic          trigger_clk;
  logic          reset_n;
  logic          I_arm, I_abort, I_rearm, I_match;
  logic [DW-1:0] I_delay;
  logic [WW-1:0] I_width, I_gap;
  logic [NW-1:0] I_num_pulses;
  logic          O_trigger, O_armed, O_busy, O_done, O_missed;

  pw_trigger_seq #(
    .pDELAY_WIDTH(DW),
    .pWIDTH_WIDTH(WW),
    .pCOUNT_WIDTH(NW)
  ) dut (
    .trigger_clk (trigger_clk),
    .reset_n     (reset_n),
    .I_arm       (I_arm),
    .I_abort     (I_abort),
    .I_rearm     (I_rearm),
    .I_match     (I_match),
    .I_delay     (I_delay),
    .I_width     (I_width),
    .I_gap       (I_gap),
    .I_num_pulses(I_num_pulses),
    .O_trigger   (O_trigger),
    .O_armed     (O_armed),
    .O_busy      (O_busy),
    .O_done      (O_done),
    .O_missed    (O_missed)
  );

  // Free-running clock, period 10.
  initial trigger_clk = 1'b0;
  always #5 trigger_clk = ~trigger_clk;

  int     testCount = 0;
  int     failCount = 0;
  longint cyc = 0;

  // Configuration presented on the next arm request.
  logic [DW-1:0] cfgDelay;
  logic [WW-1:0] cfgWidth, cfgGap;
  logic [NW-1:0] cfgNum;
  logic          cfgRearm;

  // Reference model: mode 0 idle, 1 armed, 2 running a train that was
  // triggered by a match in cycle mT.
  int     mMode;
  longint mT, mD, mW, mG, mN;
  bit     mRearm;
  bit     expTrig, expArmed, expBusy, expDone, expMissed;

  function automatic longint trainEnd();
    return mT + 1 + mD + mN * (mW + mG + 2) + mW;
  endfunction

  function automatic bit inPulse(input longint c);
    longint first, off, per;
    first = mT + 1 + mD;
    if (c < first) return 1'b0;
    off = c - first;
    per = mW + mG + 2;
    return ((off / per) <= mN) && ((off % per) <= mW);
  endfunction

  task automatic modelReset();
    mMode = 0; mT = 0; mD = 0; mW = 0; mG = 0; mN = 0; mRearm = 1'b0;
    expTrig = 1'b0; expArmed = 1'b0; expBusy = 1'b0; expDone = 1'b0; expMissed = 1'b0;
  endtask

  // Advance the model across the edge that ends cycle cyc.
  task automatic modelStep();
    bit nDone, nMissed;
    nDone = 1'b0;
    nMissed = 1'b0;
    if (mMode == 2 && !I_abort) begin
      nMissed = I_match;
      if (cyc == trainEnd()) nDone = 1'b1;
    end
    if (I_abort) begin
      mMode = 0;
    end else begin
      case (mMode)
        0: if (I_arm) begin
          mD = I_delay; mW = I_width; mG = I_gap; mN = I_num_pulses;
          mRearm = I_rearm; mMode = 1;
        end
        1: if (I_match) begin
          mT = cyc; mMode = 2;
        end
        default: if (cyc == trainEnd()) mMode = mRearm ? 1 : 0;
      endcase
    end
    expArmed  = (mMode == 1);
    expBusy   = (mMode == 2);
    expTrig   = (mMode == 2) && inPulse(cyc + 1);
    expDone   = nDone;
    expMissed = nMissed;
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  task automatic checkInt(input string tag, input longint obs, input longint exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    checkBit("trigger", O_trigger, expTrig);
    checkBit("armed",   O_armed,   expArmed);
    checkBit("busy",    O_busy,    expBusy);
    checkBit("done",    O_done,    expDone);
    checkBit("missed",  O_missed,  expMissed);
  endtask

  // Drive one cycle of requests from the negedge, then check at the next
  // negedge. Fields carry the staged configuration on arm and noise
  // otherwise, since the block must ignore them after arming.
  task automatic applyStimulus(input logic arm, input logic abort, input logic match);
    I_arm   = arm;
    I_abort = abort;
    I_match = match;
    if (arm) begin
      I_delay = cfgDelay; I_width = cfgWidth; I_gap = cfgGap;
      I_num_pulses = cfgNum; I_rearm = cfgRearm;
    end else begin
      I_delay = DW'($urandom); I_width = WW'($urandom); I_gap = WW'($urandom);
      I_num_pulses = NW'($urandom); I_rearm = 1'($urandom);
    end
    modelStep();
    @(posedge trigger_clk);
    cyc++;
    @(negedge trigger_clk);
    I_arm = 1'b0; I_abort = 1'b0; I_match = 1'b0;
    checkOutput();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  task automatic setCfg(input int d, input int w, input int g, input int n, input bit r);
    cfgDelay = DW'(d); cfgWidth = WW'(w); cfgGap = WW'(g); cfgNum = NW'(n); cfgRearm = r;
  endtask

  initial begin
    longint tStart, firstSeen;
    int     pulses;
    logic   prevTrig;
    int     r;

    reset_n = 1'b0;
    I_arm = 1'b0; I_abort = 1'b0; I_rearm = 1'b0; I_match = 1'b0;
    I_delay = '0; I_width = '0; I_gap = '0; I_num_pulses = '0;
    setCfg(0, 0, 0, 0, 1'b0);
    modelReset();

    // Reset values.
    @(negedge trigger_clk);
    checkOutput();
    @(negedge trigger_clk);
    reset_n = 1'b1;
    checkOutput();

    // Basic train: single one-cycle pulse, no rearm.
    $display("[TB] basic train");
    setCfg(0, 0, 0, 0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    while (cyc < 10) applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkBit("basicPulse", O_trigger, 1'b1);
    idleCycles(4);

    // Delay plus a three-pulse train.
    $display("[TB] delay and train");
    setCfg(5, 2, 1, 2, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    idleCycles(2);
    applyStimulus(1'b0, 1'b0, 1'b1);
    idleCycles(22);

    // Rearm, missed match in DELAY, new match in the done cycle.
    $display("[TB] rearm and missed");
    setCfg(3, 1, 0, 0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    idleCycles(1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    idleCycles(1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkBit("missedInDelay", O_missed, 1'b1);
    idleCycles(3);
    checkBit("doneBeforeRematch", O_done, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkBit("rematchBusy", O_busy, 1'b1);
    idleCycles(10);
    applyStimulus(1'b0, 1'b1, 1'b0);

    // Abort mid-pulse with a simultaneous arm.
    $display("[TB] abort");
    setCfg(0, 10, 0, 0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    idleCycles(1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    idleCycles(3);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkBit("abortTrigger", O_trigger, 1'b0);
    idleCycles(14);
    checkBit("abortStaysIdle", O_armed, 1'b0);

    // Arm and match together in IDLE: armed, no trigger.
    $display("[TB] arm with match");
    setCfg(0, 0, 0, 0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    idleCycles(3);
    checkBit("armMatchNoTrig", O_trigger, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);

    // Full-scale delay: first edge at t+2^DW.
    $display("[TB] max delay");
    setCfg((1 << DW) - 1, 0, 0, 0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    tStart = cyc;
    applyStimulus(1'b0, 1'b0, 1'b1);
    firstSeen = -1;
    for (int i = 0; i < (1 << DW) + 100 && firstSeen < 0; i++) begin
      if (O_trigger === 1'b1) firstSeen = cyc;
      else applyStimulus(1'b0, 1'b0, 1'b0);
    end
    checkInt("maxDelayEdge", firstSeen - tStart, longint'(1 << DW));
    idleCycles(3);

    // Sixteen pulses from the largest pulse count.
    $display("[TB] max pulse count");
    setCfg(2, 0, 0, 15, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    pulses = 0;
    prevTrig = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (O_trigger === 1'b1 && prevTrig !== 1'b1) pulses++;
      prevTrig = O_trigger;
      if (O_done === 1'b1) break;
      applyStimulus(1'b0, 1'b0, 1'b0);
    end
    checkInt("pulseCount", pulses, 16);
    idleCycles(2);

    // Asynchronous reset in GAP, between clock edges.
    $display("[TB] async reset");
    setCfg(0, 1, 5, 1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    idleCycles(2);
    checkBit("inGapBusy", O_busy, 1'b1);
    @(posedge trigger_clk);
    cyc++;
    #2 reset_n = 1'b0;
    #1;
    modelReset();
    checkOutput();
    @(negedge trigger_clk);
    reset_n = 1'b1;
    checkOutput();
    setCfg(1, 0, 0, 0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkBit("armAfterReset", O_armed, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);

    // Randomized traffic against the model.
    $display("[TB] random traffic");
    for (int it = 0; it < 25; it++) begin
      setCfg($urandom_range(0, 40), $urandom_range(0, 5), $urandom_range(0, 5),
             $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      applyStimulus(1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 150; k++) begin
        r = $urandom_range(0, 999);
        applyStimulus(r < 50, r > 995, ($urandom_range(0, 99) < 10));
      end
      applyStimulus(1'b0, 1'b1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
